// File: rtl/hazard_controller_pkg.sv
// Shared type packages for the pipeline controller slice.
package BasicTypes;
  typedef logic [4:0] RegAddr;
endpackage

package PipelineTypes;
  localparam int PEND_W = 2;

  typedef enum logic [1:0] {
    CTRL_RUN,
    CTRL_DRAIN,
    CTRL_HALTED
  } CtrlState;
endpackage

// File: rtl/controller_if.sv
// Controller signal bundle shared between the hazard controller and the front end.
interface ControllerIF;
  logic isDataHazard;
  logic fetchStall;
  logic flushFD;
  logic halted;

  modport controller (output isDataHazard, output fetchStall, output flushFD, output halted);
  modport decode (input isDataHazard, input flushFD);
  modport fetch (input fetchStall, input flushFD, input halted);
endinterface

// File: rtl/hazard_controller_scoreboard.sv
// Per-register pending-write counters with busy lookup, saturation and drain status.
module scoreboard
  import BasicTypes::*;
#(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   issueEn,
  input  RegAddr issueAddr,
  input  logic   retireEn,
  input  RegAddr retireAddr,
  input  RegAddr rs1Addr,
  input  RegAddr rs2Addr,
  input  RegAddr rdAddr,
  output logic   rs1Busy,
  output logic   rs2Busy,
  output logic   rdSat,
  output logic   allClearNext,
  output logic   scbErr
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;
  localparam logic [PEND_W-1:0] PEND_ONE = {{(PEND_W-1){1'b0}}, 1'b1};

  logic [PEND_W-1:0] pend     [NUM_REGS];
  logic [PEND_W-1:0] pendNext [NUM_REGS];
  logic              errNext;

  // Next counter values: issue counts up, retire counts down, both together cancel; x0 is pinned at zero.
  always_comb begin
    errNext      = scbErr;
    allClearNext = 1'b1;
    for (int r = 0; r < NUM_REGS; r++) begin
      pendNext[r] = pend[r];
      if (r == 0) begin
        pendNext[r] = '0;
      end else begin
        if (retireEn && (retireAddr == RegAddr'(r)) && (pend[r] == '0)) begin
          errNext = 1'b1;
        end
        if (issueEn && (issueAddr == RegAddr'(r))) begin
          if (!(retireEn && (retireAddr == RegAddr'(r))) && (pend[r] != PEND_MAX)) begin
            pendNext[r] = pend[r] + PEND_ONE;
          end
        end else if (retireEn && (retireAddr == RegAddr'(r)) && (pend[r] != '0)) begin
          pendNext[r] = pend[r] - PEND_ONE;
        end
      end
      if (pendNext[r] != '0) begin
        allClearNext = 1'b0;
      end
    end
  end

  // Lookups use the current counters only, so a retire this cycle does not bypass the stall.
  always_comb begin
    rs1Busy = (rs1Addr != '0) && (pend[rs1Addr] != '0);
    rs2Busy = (rs2Addr != '0) && (pend[rs2Addr] != '0);
    rdSat   = (rdAddr != '0) && (pend[rdAddr] == PEND_MAX);
  end

  // Counters and the sticky error flag advance on the falling edge alongside the pipeline registers.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend[r] <= '0;
      end
      scbErr <= 1'b0;
    end else begin
      for (int r = 0; r < NUM_REGS; r++) begin
        pend[r] <= pendNext[r];
      end
      scbErr <= errNext;
    end
  end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: RAW stalls, branch flush and halt drain.
module hazard_controller
  import BasicTypes::*;
  import PipelineTypes::*;
#(
  parameter int NUM_REGS = 32,
  parameter int PEND_W   = PipelineTypes::PEND_W
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   decValid,
  input  RegAddr rs1Addr,
  input  RegAddr rs2Addr,
  input  logic   rs1Used,
  input  logic   rs2Used,
  input  logic   decWEnable,
  input  RegAddr decRdAddr,
  input  logic   decIsHalt,
  input  logic   wbWEnable,
  input  RegAddr wbRdAddr,
  input  logic   brTaken,
  output logic   isDataHazard,
  output logic   fetchStall,
  output logic   flushFD,
  output logic   halted,
  output logic   scbErr
);

  CtrlState state, stateNext;

  logic run;
  logic raw;
  logic issue;
  logic issueEn;
  logic retireEn;
  logic rs1Busy, rs2Busy, rdSat;
  logic allClearNext;

  ControllerIF ctrlIf ();

  scoreboard #(
    .NUM_REGS (NUM_REGS),
    .PEND_W   (PEND_W)
  ) u_scoreboard (
    .clk          (clk),
    .rst          (rst),
    .issueEn      (issueEn),
    .issueAddr    (decRdAddr),
    .retireEn     (retireEn),
    .retireAddr   (wbRdAddr),
    .rs1Addr      (rs1Addr),
    .rs2Addr      (rs2Addr),
    .rdAddr       (decRdAddr),
    .rs1Busy      (rs1Busy),
    .rs2Busy      (rs2Busy),
    .rdSat        (rdSat),
    .allClearNext (allClearNext),
    .scbErr       (scbErr)
  );

  // Hazard, flush and issue decisions; outside RUN the Decode slot is treated as a bubble.
  always_comb begin
    run      = (state == CTRL_RUN);
    raw      = decValid && run &&
               ((rs1Used && rs1Busy) || (rs2Used && rs2Busy) || (decWEnable && rdSat));
    ctrlIf.flushFD      = brTaken && run;
    ctrlIf.isDataHazard = raw && !brTaken;
    ctrlIf.fetchStall   = ctrlIf.isDataHazard || !run;
    ctrlIf.halted       = (state == CTRL_HALTED);
    issue    = decValid && !ctrlIf.isDataHazard && !ctrlIf.flushFD && run;
    issueEn  = issue && decWEnable && (decRdAddr != '0);
    retireEn = wbWEnable && (wbRdAddr != '0);
  end

  // Halt issue starts the drain; drain completes once the post-retire scoreboard is empty.
  always_comb begin
    stateNext = state;
    case (state)
      CTRL_RUN:    if (issue && decIsHalt) stateNext = CTRL_DRAIN;
      CTRL_DRAIN:  if (allClearNext) stateNext = CTRL_HALTED;
      CTRL_HALTED: stateNext = CTRL_HALTED;
      default:     stateNext = CTRL_RUN;
    endcase
  end

  // Controller state register, falling edge like the rest of the pipeline.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      state <= CTRL_RUN;
    end else begin
      state <= stateNext;
    end
  end

  assign isDataHazard = ctrlIf.isDataHazard;
  assign fetchStall   = ctrlIf.fetchStall;
  assign flushFD      = ctrlIf.flushFD;
  assign halted       = ctrlIf.halted;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller.
module tb_hazard_controller;
  logic       clk;
  logic       rst;
  logic       decValid;
  logic [4:0] rs1Addr, rs2Addr;
  logic       rs1Used, rs2Used;
  logic       decWEnable;
  logic [4:0] decRdAddr;
  logic       decIsHalt;
  logic       wbWEnable;
  logic [4:0] wbRdAddr;
  logic       brTaken;
  logic       isDataHazard, fetchStall, flushFD, halted, scbErr;

  int checks   = 0;
  int failures = 0;

  hazard_controller #(.NUM_REGS(32), .PEND_W(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .decValid     (decValid),
    .rs1Addr      (rs1Addr),
    .rs2Addr      (rs2Addr),
    .rs1Used      (rs1Used),
    .rs2Used      (rs2Used),
    .decWEnable   (decWEnable),
    .decRdAddr    (decRdAddr),
    .decIsHalt    (decIsHalt),
    .wbWEnable    (wbWEnable),
    .wbRdAddr     (wbRdAddr),
    .brTaken      (brTaken),
    .isDataHazard (isDataHazard),
    .fetchStall   (fetchStall),
    .flushFD      (flushFD),
    .halted       (halted),
    .scbErr       (scbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle();
    decValid = 0; rs1Addr = 0; rs2Addr = 0; rs1Used = 0; rs2Used = 0;
    decWEnable = 0; decRdAddr = 0; decIsHalt = 0;
    wbWEnable = 0; wbRdAddr = 0; brTaken = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic issueWrite(input logic [4:0] rd);
    idle(); decValid = 1; decWEnable = 1; decRdAddr = rd;
    tick();
  endtask

  task automatic test_reset();
    rst = 0; idle();
    #2;
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_halted: got %0b expected 0", halted); end
    checks++; if (scbErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_scbErr: got %0b expected 0", scbErr); end
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL reset_hazard: got %0b expected 0", isDataHazard); end
    checks++; if (flushFD !== 1'b0) begin failures++; $display("[TB] FAIL reset_flush: got %0b expected 0", flushFD); end
    checks++; if (fetchStall !== 1'b0) begin failures++; $display("[TB] FAIL reset_fetchStall: got %0b expected 0", fetchStall); end
    tick();
    rst = 1;
    #1;
  endtask

  task automatic test_raw_stall();
    idle(); decValid = 1; decWEnable = 1; decRdAddr = 5;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL raw_producer: hazard=%0b expected 0", isDataHazard); end
    tick();
    idle(); decValid = 1; rs1Addr = 5; rs1Used = 1;
    #1;
    checks++; if (isDataHazard !== 1'b1) begin failures++; $display("[TB] FAIL raw_stall: hazard=%0b expected 1", isDataHazard); end
    checks++; if (fetchStall !== 1'b1) begin failures++; $display("[TB] FAIL raw_fetchStall: got %0b expected 1", fetchStall); end
    tick();
    wbWEnable = 1; wbRdAddr = 5;
    #1;
    checks++; if (isDataHazard !== 1'b1) begin failures++; $display("[TB] FAIL raw_no_bypass: hazard=%0b expected 1", isDataHazard); end
    tick();
    wbWEnable = 0; wbRdAddr = 0;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL raw_release: hazard=%0b expected 0", isDataHazard); end
    checks++; if (fetchStall !== 1'b0) begin failures++; $display("[TB] FAIL raw_release_fetch: got %0b expected 0", fetchStall); end
    tick();
    idle();
  endtask

  task automatic test_x0_unused();
    issueWrite(5'd0);
    idle(); decValid = 1; rs1Addr = 0; rs1Used = 1; rs2Addr = 0; rs2Used = 1;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL x0_read: hazard=%0b expected 0", isDataHazard); end
    tick();
    issueWrite(5'd7);
    idle(); decValid = 1; rs2Addr = 7; rs2Used = 0;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL unused_rs2: hazard=%0b expected 0", isDataHazard); end
    rs2Used = 1;
    #1;
    checks++; if (isDataHazard !== 1'b1) begin failures++; $display("[TB] FAIL used_rs2: hazard=%0b expected 1", isDataHazard); end
    idle(); wbWEnable = 1; wbRdAddr = 7;
    tick();
    idle(); wbWEnable = 1; wbRdAddr = 0;
    tick();
    idle();
    #1;
    checks++; if (scbErr !== 1'b0) begin failures++; $display("[TB] FAIL x0_retire_err: scbErr=%0b expected 0", scbErr); end
  endtask

  task automatic test_saturation();
    issueWrite(5'd3);
    issueWrite(5'd3);
    idle(); decValid = 1; decWEnable = 1; decRdAddr = 3;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL sat_third: hazard=%0b expected 0", isDataHazard); end
    tick();
    wbWEnable = 1; wbRdAddr = 3;
    #1;
    checks++; if (isDataHazard !== 1'b1) begin failures++; $display("[TB] FAIL sat_fourth: hazard=%0b expected 1", isDataHazard); end
    tick();
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL sat_simul: hazard=%0b expected 0", isDataHazard); end
    tick();
    wbWEnable = 0; wbRdAddr = 0;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL sat_refill: hazard=%0b expected 0", isDataHazard); end
    tick();
    #1;
    checks++; if (isDataHazard !== 1'b1) begin failures++; $display("[TB] FAIL sat_again: hazard=%0b expected 1", isDataHazard); end
    idle(); decValid = 1; rs2Addr = 3; rs2Used = 1; wbWEnable = 1; wbRdAddr = 3;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (isDataHazard !== 1'b1) begin failures++; $display("[TB] FAIL sat_drain%0d: hazard=%0b expected 1", i, isDataHazard); end
      tick();
    end
    wbWEnable = 0; wbRdAddr = 0;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL sat_empty: hazard=%0b expected 0", isDataHazard); end
    checks++; if (scbErr !== 1'b0) begin failures++; $display("[TB] FAIL sat_err: scbErr=%0b expected 0", scbErr); end
    tick();
    idle();
  endtask

  task automatic test_branch();
    issueWrite(5'd6);
    idle(); decValid = 1; rs1Addr = 6; rs1Used = 1; decWEnable = 1; decRdAddr = 8; brTaken = 1;
    #1;
    checks++; if (flushFD !== 1'b1) begin failures++; $display("[TB] FAIL br_flush: got %0b expected 1", flushFD); end
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL br_priority: hazard=%0b expected 0", isDataHazard); end
    checks++; if (fetchStall !== 1'b0) begin failures++; $display("[TB] FAIL br_fetchStall: got %0b expected 0", fetchStall); end
    tick();
    idle(); decValid = 1; rs1Addr = 8; rs1Used = 1; wbWEnable = 1; wbRdAddr = 6;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL br_squashed: hazard=%0b expected 0", isDataHazard); end
    checks++; if (flushFD !== 1'b0) begin failures++; $display("[TB] FAIL br_noflush: got %0b expected 0", flushFD); end
    tick();
    idle();
  endtask

  task automatic test_halt_drain();
    issueWrite(5'd2);
    issueWrite(5'd9);
    idle(); decValid = 1; decIsHalt = 1;
    #1;
    checks++; if (fetchStall !== 1'b0) begin failures++; $display("[TB] FAIL halt_issue: fetchStall=%0b expected 0", fetchStall); end
    tick();
    idle(); decValid = 1; rs1Addr = 2; rs1Used = 1; decWEnable = 1; decRdAddr = 11; brTaken = 1;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL drain_hazard: got %0b expected 0", isDataHazard); end
    checks++; if (flushFD !== 1'b0) begin failures++; $display("[TB] FAIL drain_flush: got %0b expected 0", flushFD); end
    checks++; if (fetchStall !== 1'b1) begin failures++; $display("[TB] FAIL drain_fetchStall: got %0b expected 1", fetchStall); end
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL drain_halted: got %0b expected 0", halted); end
    tick();
    idle(); wbWEnable = 1; wbRdAddr = 2;
    tick();
    wbRdAddr = 9;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL drain_last: halted=%0b expected 0", halted); end
    checks++; if (fetchStall !== 1'b1) begin failures++; $display("[TB] FAIL drain_last_fetch: got %0b expected 1", fetchStall); end
    tick();
    idle();
    #1;
    checks++; if (halted !== 1'b1) begin failures++; $display("[TB] FAIL halted: got %0b expected 1", halted); end
    checks++; if (fetchStall !== 1'b1) begin failures++; $display("[TB] FAIL halted_fetch: got %0b expected 1", fetchStall); end
  endtask

  task automatic test_error_reset();
    rst = 0;
    #1;
    checks++; if (halted !== 1'b0) begin failures++; $display("[TB] FAIL reset_from_halt: halted=%0b expected 0", halted); end
    rst = 1;
    tick();
    idle(); wbWEnable = 1; wbRdAddr = 4;
    #1;
    checks++; if (scbErr !== 1'b0) begin failures++; $display("[TB] FAIL err_before: scbErr=%0b expected 0", scbErr); end
    tick();
    idle();
    #1;
    checks++; if (scbErr !== 1'b1) begin failures++; $display("[TB] FAIL err_set: scbErr=%0b expected 1", scbErr); end
    issueWrite(5'd4);
    idle(); decValid = 1; rs1Addr = 4; rs1Used = 1; wbWEnable = 1; wbRdAddr = 4;
    #1;
    checks++; if (isDataHazard !== 1'b1) begin failures++; $display("[TB] FAIL err_pend_one: hazard=%0b expected 1", isDataHazard); end
    tick();
    wbWEnable = 0; wbRdAddr = 0;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL err_pend_zero: hazard=%0b expected 0", isDataHazard); end
    tick();
    issueWrite(5'd10);
    idle(); decValid = 1; decIsHalt = 1;
    tick();
    idle();
    #1;
    checks++; if (fetchStall !== 1'b1) begin failures++; $display("[TB] FAIL pre_reset_drain: fetchStall=%0b expected 1", fetchStall); end
    rst = 0;
    #1;
    checks++; if (scbErr !== 1'b0) begin failures++; $display("[TB] FAIL reset_err_clear: scbErr=%0b expected 0", scbErr); end
    checks++; if (fetchStall !== 1'b0) begin failures++; $display("[TB] FAIL reset_run: fetchStall=%0b expected 0", fetchStall); end
    brTaken = 1;
    #1;
    checks++; if (flushFD !== 1'b1) begin failures++; $display("[TB] FAIL reset_run_flush: flushFD=%0b expected 1", flushFD); end
    brTaken = 0; rst = 1;
    #1;
    decValid = 1; rs1Addr = 10; rs1Used = 1;
    #1;
    checks++; if (isDataHazard !== 1'b0) begin failures++; $display("[TB] FAIL reset_scb_clear: hazard=%0b expected 0", isDataHazard); end
    tick();
    idle();
  endtask

  initial begin
    test_reset();
    test_raw_stall();
    test_x0_unused();
    test_saturation();
    test_branch();
    test_halt_drain();
    test_error_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
